// File: rtl/boot_mem.sv
// boot_mem: CPU data RAM with a boot loader FSM, CPU reset control and retire counter.
// Define BOOT_CHECKSUM_EN to require a trailing checksum word after each boot image.
module boot_mem #(
    parameter int Wwid    = 6,
    parameter int aW      = 6,
    parameter int LOADLEN = 64,
    parameter int RETW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_start,
    input  logic [Wwid-1:0] ld_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [aW-1:0]   memAddr,
    input  logic [Wwid-1:0] writeData,
    input  logic            writeEn,
    output logic [Wwid-1:0] readData,
    output logic            cpu_rst,
    input  logic            ihalt,
    input  logic            iretire,
    output logic [2:0]      state,
    output logic [RETW-1:0] retire_cnt,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [aW-1:0] LAST = aW'(LOADLEN - 1);

    state_t          st;
    logic [aW-1:0]   ldptr;
    logic [Wwid-1:0] mem [0:2**aW-1];
    logic            ld_hs;
    logic            load_we;
    logic            cpu_we;
    logic            start_ok;

`ifdef BOOT_CHECKSUM_EN
    logic [Wwid-1:0] sum;
    logic            cks_ph;
`endif

    assign ld_hs    = ld_valid && (st == S_LOAD);
    assign cpu_we   = writeEn && (st == S_RUN);
    assign start_ok = ld_start &&
                      (st == S_IDLE || st == S_HALT || st == S_ERR);

`ifdef BOOT_CHECKSUM_EN
    // The checksum word itself never lands in RAM.
    assign load_we = ld_hs && !cks_ph;
`else
    assign load_we = ld_hs;
`endif

    assign state    = st;
    assign ld_ready = (st == S_LOAD);
    assign cpu_rst  = (st != S_RUN);
    assign done     = (st == S_HALT);
`ifdef BOOT_CHECKSUM_EN
    assign err      = (st == S_ERR);
`else
    assign err      = 1'b0;
`endif

    assign readData = mem[memAddr];

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[ldptr] <= ld_data;
        end else if (cpu_we) begin
            mem[memAddr] <= writeData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= S_IDLE;
            ldptr      <= '0;
            retire_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum        <= '0;
            cks_ph     <= 1'b0;
`endif
        end else if (start_ok) begin
            st         <= S_LOAD;
            ldptr      <= '0;
            retire_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum        <= '0;
            cks_ph     <= 1'b0;
`endif
        end else begin
            unique case (st)
                S_LOAD: begin
                    if (ld_hs) begin
`ifdef BOOT_CHECKSUM_EN
                        if (cks_ph) begin
                            st     <= (ld_data == sum) ? S_RUN : S_ERR;
                            cks_ph <= 1'b0;
                            ldptr  <= '0;
                        end else begin
                            sum <= sum + ld_data;
                            if (ldptr == LAST) begin
                                cks_ph <= 1'b1;
                                ldptr  <= '0;
                            end else begin
                                ldptr <= ldptr + 1'b1;
                            end
                        end
`else
                        if (ldptr == LAST) begin
                            st    <= S_RUN;
                            ldptr <= '0;
                        end else begin
                            ldptr <= ldptr + 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    // A retire in the halt cycle still counts.
                    if (iretire && (retire_cnt != '1)) begin
                        retire_cnt <= retire_cnt + 1'b1;
                    end
                    if (ihalt) begin
                        st <= S_HALT;
                    end
                end
                S_IDLE, S_HALT, S_ERR: begin
                    st <= st;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_mem.sv
// Directed testbench for boot_mem with LOADLEN=4 and a 3-bit retire counter.
// Compile with BOOT_CHECKSUM_EN defined to also exercise the checksum path.
module tb_boot_mem;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld_start = 1'b0;
    logic [5:0] ld_data = '0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [5:0] memAddr = '0;
    logic [5:0] writeData = '0;
    logic       writeEn = 1'b0;
    logic [5:0] readData;
    logic       cpu_rst;
    logic       ihalt = 1'b0;
    logic       iretire = 1'b0;
    logic [2:0] state;
    logic [2:0] retire_cnt;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    boot_mem #(
        .Wwid(6), .aW(6), .LOADLEN(4), .RETW(3)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_data(ld_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .memAddr(memAddr), .writeData(writeData),
        .writeEn(writeEn), .readData(readData),
        .cpu_rst(cpu_rst), .ihalt(ihalt), .iretire(iretire),
        .state(state), .retire_cnt(retire_cnt),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    // Pushes four words with a one-cycle valid gap before each,
    // then the checksum word when that feature is built in.
    task automatic push_words(input logic [23:0] w,
                              input logic [5:0] cks);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b0;
            tick();
            ld_valid = 1'b1;
            ld_data  = w[i*6 +: 6];
            tick();
        end
`ifdef BOOT_CHECKSUM_EN
        ld_data = cks;
        tick();
`else
        ld_data = cks;
`endif
        ld_valid = 1'b0;
    endtask

    task automatic halt_cpu();
        ihalt = 1'b1;
        tick();
        ihalt = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++;
        if (state !== 3'd0 || cpu_rst !== 1'b1 || ld_ready !== 1'b0 ||
            retire_cnt !== 3'd0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset: st=%0d cr=%b rdy=%b rc=%0d dn=%b er=%b want 0 1 0 0 0 0",
                     state, cpu_rst, ld_ready, retire_cnt, done, err);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_load();
        logic [5:0] exp [4];
        exp[0] = 6'd5; exp[1] = 6'd9; exp[2] = 6'd17; exp[3] = 6'd33;
        start_load();
        total++;
        if (state !== 3'd1 || ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_enter: st=%0d rdy=%b want 1 1", state, ld_ready);
        end
        push_words({6'd33, 6'd17, 6'd9, 6'd5}, 6'd0);
        total++;
        if (state !== 3'd2 || cpu_rst !== 1'b0 || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_run: st=%0d cr=%b rdy=%b want 2 0 0",
                     state, cpu_rst, ld_ready);
        end
        for (int i = 0; i < 4; i++) begin
            memAddr = 6'(i);
            #1;
            total++;
            if (readData !== exp[i]) begin
                bad++;
                $display("FAIL load_ram%0d: got %0d want %0d", i, readData, exp[i]);
            end
        end
    endtask

    task automatic test_store();
        writeEn   = 1'b1;
        memAddr   = 6'd10;
        writeData = 6'd42;
        tick();
        memAddr   = 6'd11;
        writeData = 6'd20;
        tick();
        writeEn   = 1'b0;
        memAddr   = 6'd10;
        #1;
        total++;
        if (readData !== 6'd42) begin
            bad++;
            $display("FAIL store10: got %0d want 42", readData);
        end
        memAddr = 6'd11;
        #1;
        total++;
        if (readData !== 6'd20) begin
            bad++;
            $display("FAIL store11: got %0d want 20", readData);
        end
    endtask

    task automatic test_retire_halt();
        iretire = 1'b1;
        tick(); tick(); tick();
        ihalt = 1'b1;
        tick();
        ihalt   = 1'b0;
        iretire = 1'b0;
        total++;
        if (retire_cnt !== 3'd4 || state !== 3'd3 ||
            done !== 1'b1 || cpu_rst !== 1'b1) begin
            bad++;
            $display("FAIL retire_halt: rc=%0d st=%0d dn=%b cr=%b want 4 3 1 1",
                     retire_cnt, state, done, cpu_rst);
        end
        // Stores while halted must not land.
        writeEn   = 1'b1;
        memAddr   = 6'd10;
        writeData = 6'd3;
        tick();
        writeEn = 1'b0;
        #1;
        total++;
        if (readData !== 6'd42) begin
            bad++;
            $display("FAIL halt_store: got %0d want 42", readData);
        end
    endtask

    task automatic test_reload();
        start_load();
        total++;
        if (state !== 3'd1 || retire_cnt !== 3'd0) begin
            bad++;
            $display("FAIL reload_enter: st=%0d rc=%0d want 1 0", state, retire_cnt);
        end
        writeEn   = 1'b1;
        memAddr   = 6'd11;
        writeData = 6'd7;
        push_words({6'd4, 6'd3, 6'd2, 6'd1}, 6'd10);
        writeEn = 1'b0;
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL reload_run: st=%0d want 2", state);
        end
        #1;
        total++;
        if (readData !== 6'd20) begin
            bad++;
            $display("FAIL load_store11: got %0d want 20", readData);
        end
        memAddr = 6'd0;
        #1;
        total++;
        if (readData !== 6'd1) begin
            bad++;
            $display("FAIL reload_ram0: got %0d want 1", readData);
        end
        memAddr = 6'd3;
        #1;
        total++;
        if (readData !== 6'd4) begin
            bad++;
            $display("FAIL reload_ram3: got %0d want 4", readData);
        end
    endtask

    task automatic test_saturate();
        ld_start = 1'b1;
        iretire  = 1'b1;
        tick();
        ld_start = 1'b0;
        total++;
        if (state !== 3'd2 || retire_cnt !== 3'd1) begin
            bad++;
            $display("FAIL run_start_ignored: st=%0d rc=%0d want 2 1",
                     state, retire_cnt);
        end
        for (int i = 0; i < 9; i++) tick();
        iretire = 1'b0;
        total++;
        if (retire_cnt !== 3'd7) begin
            bad++;
            $display("FAIL saturate: got %0d want 7", retire_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        halt_cpu();
        start_load();
        ld_valid = 1'b1;
        ld_data  = 6'd11;
        tick();
        ld_data  = 6'd12;
        tick();
        ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || ld_ready !== 1'b0 || retire_cnt !== 3'd0) begin
            bad++;
            $display("FAIL rst_mid_load: st=%0d rdy=%b rc=%0d want 0 0 0",
                     state, ld_ready, retire_cnt);
        end
        rst = 1'b0;
        tick();
        start_load();
        push_words({6'd24, 6'd23, 6'd22, 6'd21}, 6'd26);
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL rst_reload_run: st=%0d want 2", state);
        end
        memAddr = 6'd0;
        #1;
        total++;
        if (readData !== 6'd21) begin
            bad++;
            $display("FAIL rst_reload_ram0: got %0d want 21", readData);
        end
        memAddr = 6'd2;
        #1;
        total++;
        if (readData !== 6'd23) begin
            bad++;
            $display("FAIL rst_reload_ram2: got %0d want 23", readData);
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        halt_cpu();
        start_load();
        push_words({6'd33, 6'd17, 6'd9, 6'd5}, 6'd1);
        total++;
        if (state !== 3'd4 || err !== 1'b1 || cpu_rst !== 1'b1) begin
            bad++;
            $display("FAIL cks_bad: st=%0d er=%b cr=%b want 4 1 1",
                     state, err, cpu_rst);
        end
        start_load();
        total++;
        if (state !== 3'd1 || err !== 1'b0) begin
            bad++;
            $display("FAIL cks_err_reload: st=%0d er=%b want 1 0", state, err);
        end
        push_words({6'd33, 6'd17, 6'd9, 6'd5}, 6'd0);
        total++;
        if (state !== 3'd2 || err !== 1'b0) begin
            bad++;
            $display("FAIL cks_good: st=%0d er=%b want 2 0", state, err);
        end
    endtask
`else
    task automatic test_no_err();
        halt_cpu();
        total++;
        if (err !== 1'b0 || state !== 3'd3) begin
            bad++;
            $display("FAIL no_err: er=%b st=%0d want 0 3", err, state);
        end
    endtask
`endif

    initial begin
        test_reset();
        tick();
        test_load();
        test_store();
        test_retire_halt();
        test_reload();
        test_saturate();
        test_reset_mid_load();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`else
        test_no_err();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
